// File: rtl/pam5_dfe_slicer.sv
// ============================================================================
// pam5_dfe_slicer
// ----------------------------------------------------------------------------
// Multi-channel PAM5 decision-feedback slicer. Each channel subtracts the
// post-cursor ISI estimate (active taps x past symbols) from its FFE sample.
// It slices the result to a symbol in {-2..+2} and reports the slicer error
// against the ideal level of the reference symbol. The reference symbol is
// the decision, or the known training symbol while training is enabled. The
// reference is what enters the feedback history.
//
// Ports
//   clock       rising-edge clock
//   reset_n     asynchronous active-low reset
//   in_valid    in_samples / train_syms valid
//   in_ready    block can accept a vector (!out_valid || out_ready)
//   in_samples  N_CH signed samples, ch0 in the MSB slice
//   train_en    feedback uses train_syms instead of decisions
//   train_syms  N_CH signed 3-bit known symbols, ch0 in the MSB slice
//   hist_clear  zero all decision histories on the next edge
//   tap_wr_en   write one shadow tap (tap_ch, tap_idx, tap_data)
//   tap_ch      shadow tap channel
//   tap_idx     shadow tap index, 0 = most recent symbol
//   tap_data    signed tap value, in sample LSBs per unit symbol
//   tap_commit  copy the whole shadow bank into the active bank
//   out_valid   out_syms / out_err valid
//   out_ready   consumer accepts the output
//   out_syms    N_CH signed 3-bit decisions, ch0 in the MSB slice
//   out_err     N_CH signed (SAMPLE_W+2)-bit slicer errors, ch0 in the MSB slice
// ============================================================================
module pam5_dfe_slicer #(
    parameter int N_CH       = 4,
    parameter int N_TAPS     = 14,
    parameter int SAMPLE_W   = 8,
    parameter int TAP_W      = 8,
    parameter int LEVEL_STEP = 51,
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int IDX_W     = (N_TAPS > 1) ? $clog2(N_TAPS) : 1
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [N_CH*SAMPLE_W-1:0]       in_samples,
    input  logic                           train_en,
    input  logic [N_CH*3-1:0]              train_syms,
    input  logic                           hist_clear,
    input  logic                           tap_wr_en,
    input  logic [CH_W-1:0]                tap_ch,
    input  logic [IDX_W-1:0]               tap_idx,
    input  logic signed [TAP_W-1:0]        tap_data,
    input  logic                           tap_commit,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [N_CH*3-1:0]              out_syms,
    output logic [N_CH*(SAMPLE_W+2)-1:0]   out_err
);

    // ------------------------------------------------------------------------
    // Widths and constants
    // ------------------------------------------------------------------------
    localparam int F_W    = SAMPLE_W + 2;                    // equalised sample / error
    localparam int ACC_W  = TAP_W + 3 + $clog2(N_TAPS);      // feedback sum, never overflows
    localparam int PROD_W = TAP_W + 2;                       // one tap x symbol, |sym| <= 2
    localparam int MAX_W  = (ACC_W > F_W) ? ACC_W : F_W;
    // Headroom for sample - feedback and f - 2*LEVEL_STEP before saturation.
    localparam int WIDE_W = MAX_W + $clog2(LEVEL_STEP + 1) + 3;

    typedef logic signed [2:0]       sym_t;
    typedef logic signed [TAP_W-1:0] tap_t;
    typedef logic signed [F_W-1:0]   fval_t;
    typedef logic signed [WIDE_W-1:0] wide_t;

    localparam fval_t T1    = fval_t'(LEVEL_STEP / 2);
    localparam fval_t T2    = fval_t'((3 * LEVEL_STEP) / 2);
    localparam wide_t F_MAX = wide_t'((2 ** (F_W - 1)) - 1);
    localparam wide_t F_MIN = wide_t'(-(2 ** (F_W - 1)));
    localparam wide_t LVL1  = wide_t'(LEVEL_STEP);
    localparam wide_t LVL2  = wide_t'(2 * LEVEL_STEP);

    // ------------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------------

    // Tap x symbol with shift/add only: |sym| selects tap or tap<<1, the
    // sign bit negates. Codes outside -2..+2 never reach the history.
    function automatic logic signed [PROD_W-1:0] tap_x_sym(input tap_t tap, input sym_t s);
        logic signed [PROD_W-1:0] mag;
        case (s)
            3'b001, 3'b111: mag = PROD_W'(tap);
            3'b010, 3'b110: mag = PROD_W'(tap) <<< 1;
            default:        mag = '0;
        endcase
        return s[2] ? -mag : mag;
    endfunction

    function automatic fval_t saturate(input wide_t v);
        if (v > F_MAX) return fval_t'(F_MAX);
        if (v < F_MIN) return fval_t'(F_MIN);
        return fval_t'(v);
    endfunction

    function automatic sym_t slice_sym(input fval_t f);
        if (f >= T2)  return 3'sd2;
        if (f >= T1)  return 3'sd1;
        if (f > -T1)  return 3'sd0;
        if (f > -T2)  return -3'sd1;
        return -3'sd2;
    endfunction

    // The 3-bit training code can carry -4 and +3; pull those to the PAM5 range.
    function automatic sym_t clamp_sym(input sym_t s);
        if (s > 3'sd2)  return 3'sd2;
        if (s < -3'sd2) return -3'sd2;
        return s;
    endfunction

    // Ideal level of a symbol, selected from constants rather than multiplied.
    function automatic wide_t level_of(input sym_t s);
        case (s)
            3'b001:  return LVL1;
            3'b111:  return -LVL1;
            3'b010:  return LVL2;
            3'b110:  return -LVL2;
            default: return '0;
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    tap_t                shadow_q [N_CH][N_TAPS];
    tap_t                active_q [N_CH][N_TAPS];
    sym_t                hist_q   [N_CH][N_TAPS];
    logic                out_valid_q;
    logic [N_CH*3-1:0]   out_syms_q;
    logic [N_CH*F_W-1:0] out_err_q;

    logic accept;

    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_syms  = out_syms_q;
    assign out_err   = out_err_q;

    // ------------------------------------------------------------------------
    // Per-channel datapath
    // ------------------------------------------------------------------------
    logic signed [SAMPLE_W-1:0] ch_sample [N_CH];
    logic signed [ACC_W-1:0]    ch_fb     [N_CH];
    fval_t                      ch_f      [N_CH];
    sym_t                       ch_sym    [N_CH];
    sym_t                       ch_ref    [N_CH];
    fval_t                      ch_err    [N_CH];
    logic [N_CH*3-1:0]          out_syms_d;
    logic [N_CH*F_W-1:0]        out_err_d;

    always_comb begin
        // NOTE: every variable written here gets a value on every pass
        // before anything can read it; a path that skips an assignment
        // would infer a latch.
        out_syms_d = '0;
        out_err_d  = '0;
        for (int c = 0; c < N_CH; c++) begin
            ch_sample[c] = in_samples[(N_CH-1-c)*SAMPLE_W +: SAMPLE_W];
            ch_fb[c]     = '0;
            for (int k = 0; k < N_TAPS; k++) begin
                ch_fb[c] = ch_fb[c] + ACC_W'(tap_x_sym(active_q[c][k], hist_q[c][k]));
            end
            ch_f[c]   = saturate(wide_t'(ch_sample[c]) - wide_t'(ch_fb[c]));
            ch_sym[c] = slice_sym(ch_f[c]);
            ch_ref[c] = train_en ? clamp_sym(sym_t'(train_syms[(N_CH-1-c)*3 +: 3]))
                                 : ch_sym[c];
            ch_err[c] = saturate(wide_t'(ch_f[c]) - level_of(ch_ref[c]));
            out_syms_d[(N_CH-1-c)*3 +: 3]   = ch_sym[c];
            out_err_d[(N_CH-1-c)*F_W +: F_W] = ch_err[c];
        end
    end

    // ------------------------------------------------------------------------
    // Output register: 1-deep, holds while out_valid && !out_ready
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_syms_q  <= '0;
            out_err_q   <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_syms_q  <= out_syms_d;
            out_err_q   <= out_err_d;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Decision history. A clear wins over a coincident accept: that vector
    // was already sliced with the old history and its reference is dropped.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: the history and tap arrays are reset element by element.
        // A stale tap or symbol left over from before reset would bias
        // the first decisions afterwards.
        if (!reset_n) begin
            for (int c = 0; c < N_CH; c++) begin
                for (int k = 0; k < N_TAPS; k++) hist_q[c][k] <= '0;
            end
        end else if (hist_clear) begin
            for (int c = 0; c < N_CH; c++) begin
                for (int k = 0; k < N_TAPS; k++) hist_q[c][k] <= '0;
            end
        end else if (accept) begin
            for (int c = 0; c < N_CH; c++) begin
                for (int k = N_TAPS - 1; k >= 1; k--) hist_q[c][k] <= hist_q[c][k-1];
                hist_q[c][0] <= ch_ref[c];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Tap banks. A commit copies the shadow bank as it stood before this
    // edge, so a write in the same cycle lands only in the shadow bank.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < N_CH; c++) begin
                for (int k = 0; k < N_TAPS; k++) begin
                    shadow_q[c][k] <= '0;
                    active_q[c][k] <= '0;
                end
            end
        end else begin
            if (tap_wr_en && (32'(tap_ch) < N_CH) && (32'(tap_idx) < N_TAPS)) begin
                shadow_q[tap_ch][tap_idx] <= tap_data;
            end
            if (tap_commit) begin
                active_q <= shadow_q;
            end
        end
    end

endmodule

// File: tb/tb_pam5_dfe_slicer.sv
// ============================================================================
// tb_pam5_dfe_slicer
// ----------------------------------------------------------------------------
// Directed bench for pam5_dfe_slicer at default parameters (4 channels,
// 14 taps, 8-bit samples and taps, LEVEL_STEP 51 -> thresholds 25 / 76).
// Expected values are worked out by hand from the slicing rules.
// ============================================================================
module tb_pam5_dfe_slicer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_samples = '0;
    logic        train_en = 1'b0;
    logic [11:0] train_syms = '0;
    logic        hist_clear = 1'b0;
    logic        tap_wr_en = 1'b0;
    logic [1:0]  tap_ch = '0;
    logic [3:0]  tap_idx = '0;
    logic signed [7:0] tap_data = '0;
    logic        tap_commit = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [11:0] out_syms;
    logic [39:0] out_err;

    int errors = 0;
    int checks = 0;

    logic [11:0] exp_s;
    logic [39:0] exp_e;

    always #5 clock = ~clock;

    pam5_dfe_slicer dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_samples (in_samples),
        .train_en   (train_en),
        .train_syms (train_syms),
        .hist_clear (hist_clear),
        .tap_wr_en  (tap_wr_en),
        .tap_ch     (tap_ch),
        .tap_idx    (tap_idx),
        .tap_data   (tap_data),
        .tap_commit (tap_commit),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_syms   (out_syms),
        .out_err    (out_err)
    );

    // Bus packers, ch0 first (MSB slice).
    function automatic logic [11:0] psyms(input int a, input int b, input int c, input int d);
        return {3'(a), 3'(b), 3'(c), 3'(d)};
    endfunction

    function automatic logic [39:0] perr(input int a, input int b, input int c, input int d);
        return {10'(a), 10'(b), 10'(c), 10'(d)};
    endfunction

    function automatic logic [31:0] pin(input int a, input int b, input int c, input int d);
        return {8'(a), 8'(b), 8'(c), 8'(d)};
    endfunction

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input int a, input int b, input int c, input int d);
        in_samples = pin(a, b, c, d);
        in_valid   = 1'b1;
        cycle();
        in_valid   = 1'b0;
    endtask

    task automatic write_tap(input int ch, input int idx, input int val);
        tap_wr_en = 1'b1;
        tap_ch    = 2'(ch);
        tap_idx   = 4'(idx);
        tap_data  = 8'(val);
        cycle();
        tap_wr_en = 1'b0;
    endtask

    task automatic commit();
        tap_commit = 1'b1;
        cycle();
        tap_commit = 1'b0;
    endtask

    task automatic clear_hist();
        hist_clear = 1'b1;
        cycle();
        hist_clear = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        #1 reset_n = 1'b0;
        repeat (2) cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_syms !== 12'h000) begin errors++; $display("FAIL reset_out_syms: got %h want 000", out_syms); end
        checks++; if (out_err !== 40'h0) begin errors++; $display("FAIL reset_out_err: got %h want 0", out_err); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        reset_n = 1'b1;
        cycle();
    endtask

    task automatic test_basic();
        in_samples = pin(51, -103, 0, 101);
        in_valid   = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_latency: out_valid %b before edge, want 0", out_valid); end
        cycle();
        in_valid = 1'b0;
        exp_s = psyms(1, -2, 0, 2);
        exp_e = perr(0, -1, 0, -1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", out_valid); end
        checks++; if (out_syms !== exp_s) begin errors++; $display("FAIL basic_syms: got %h want %h", out_syms, exp_s); end
        checks++; if (out_err !== exp_e) begin errors++; $display("FAIL basic_err: got %h want %h", out_err, exp_e); end
        cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: out_valid %b want 0", out_valid); end
    endtask

    task automatic test_thresholds();
        send(76, 75, 25, 24);
        exp_s = psyms(2, 1, 1, 0);
        exp_e = perr(-26, 24, -26, 24);
        checks++; if (out_syms !== exp_s) begin errors++; $display("FAIL thr_pos_syms: got %h want %h", out_syms, exp_s); end
        checks++; if (out_err !== exp_e) begin errors++; $display("FAIL thr_pos_err: got %h want %h", out_err, exp_e); end
        send(-24, -25, -75, -76);
        exp_s = psyms(0, -1, -1, -2);
        exp_e = perr(-24, 26, -24, 26);
        checks++; if (out_syms !== exp_s) begin errors++; $display("FAIL thr_neg_syms: got %h want %h", out_syms, exp_s); end
        checks++; if (out_err !== exp_e) begin errors++; $display("FAIL thr_neg_err: got %h want %h", out_err, exp_e); end
    endtask

    task automatic test_taps();
        clear_hist();
        write_tap(0, 0, 10);
        // Commit coincides with this accept; the vector still sees zero taps.
        in_samples = pin(102, 0, 0, 0);
        in_valid   = 1'b1;
        tap_commit = 1'b1;
        cycle();
        in_valid   = 1'b0;
        tap_commit = 1'b0;
        exp_s = psyms(2, 0, 0, 0);
        checks++; if (out_syms !== exp_s) begin errors++; $display("FAIL taps_first_syms: got %h want %h", out_syms, exp_s); end
        checks++; if (out_err !== 40'h0) begin errors++; $display("FAIL taps_first_err: got %h want 0", out_err); end
        send(70, 0, 0, 0);   // fb = 10*2 = 20, f = 50
        exp_s = psyms(1, 0, 0, 0);
        exp_e = perr(-1, 0, 0, 0);
        checks++; if (out_syms !== exp_s) begin errors++; $display("FAIL taps_second_syms: got %h want %h", out_syms, exp_s); end
        checks++; if (out_err !== exp_e) begin errors++; $display("FAIL taps_second_err: got %h want %h", out_err, exp_e); end
    endtask

    task automatic test_back_to_back();
        logic [11:0] a_s;
        clear_hist();
        a_s = psyms(1, 0, 0, 0);
        out_ready  = 1'b0;
        in_samples = pin(51, 0, 0, 0);
        in_valid   = 1'b1;
        cycle();
        in_samples = pin(0, -51, 0, 0);   // B waits while the consumer stalls
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b want 0", in_ready); end
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++; if (out_syms !== a_s || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_%0d: syms %h valid %b want %h 1", i, out_syms, out_valid, a_s); end
            checks++; if (out_err !== 40'h0) begin errors++; $display("FAIL bp_hold_err_%0d: got %h want 0", i, out_err); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_%0d: got %b want 0", i, in_ready); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_release: got %b want 1", in_ready); end
        cycle();
        in_valid = 1'b0;
        // B: ch0 fb = 10*(+1) -> f=-10; a second history push would change this.
        exp_s = psyms(0, -1, 0, 0);
        exp_e = perr(-10, 0, 0, 0);
        checks++; if (out_syms !== exp_s) begin errors++; $display("FAIL bp_b_syms: got %h want %h", out_syms, exp_s); end
        checks++; if (out_err !== exp_e) begin errors++; $display("FAIL bp_b_err: got %h want %h", out_err, exp_e); end
    endtask

    task automatic test_train();
        clear_hist();
        train_en   = 1'b1;
        train_syms = psyms(-2, 0, 0, 0);
        send(0, 0, 0, 0);
        train_en   = 1'b0;
        exp_e = perr(102, 0, 0, 0);
        checks++; if (out_syms !== 12'h000) begin errors++; $display("FAIL train_syms_out: got %h want 000", out_syms); end
        checks++; if (out_err !== exp_e) begin errors++; $display("FAIL train_err: got %h want %h", out_err, exp_e); end
        send(0, 0, 0, 0);    // fb = 10*(-2) -> f = 20
        exp_e = perr(20, 0, 0, 0);
        checks++; if (out_syms !== 12'h000) begin errors++; $display("FAIL train_fb_syms: got %h want 000", out_syms); end
        checks++; if (out_err !== exp_e) begin errors++; $display("FAIL train_fb_err: got %h want %h", out_err, exp_e); end
        // Out-of-range training code +3 acts as +2.
        clear_hist();
        train_en   = 1'b1;
        train_syms = psyms(3, 0, 0, 0);
        send(0, 0, 0, 0);
        train_en   = 1'b0;
        exp_e = perr(-102, 0, 0, 0);
        checks++; if (out_err !== exp_e) begin errors++; $display("FAIL clamp_err: got %h want %h", out_err, exp_e); end
        send(0, 0, 0, 0);
        exp_e = perr(-20, 0, 0, 0);
        checks++; if (out_err !== exp_e) begin errors++; $display("FAIL clamp_fb_err: got %h want %h", out_err, exp_e); end
        train_syms = '0;
    endtask

    task automatic test_shadow();
        clear_hist();
        for (int i = 0; i < 14; i++) send(0, 102, 0, 0);
        write_tap(1, 13, 5);
        send(0, 0, 0, 0);
        checks++; if (out_syms !== 12'h000) begin errors++; $display("FAIL shadow_syms: got %h want 000", out_syms); end
        checks++; if (out_err !== 40'h0) begin errors++; $display("FAIL shadow_err: got %h want 0", out_err); end
        // Commit with a simultaneous write: active takes 5, shadow becomes 7.
        tap_wr_en  = 1'b1;
        tap_ch     = 2'd1;
        tap_idx    = 4'd13;
        tap_data   = 8'sd7;
        tap_commit = 1'b1;
        cycle();
        tap_wr_en  = 1'b0;
        tap_commit = 1'b0;
        send(0, 0, 0, 0);    // hist[1][13] = +2 -> fb 10
        exp_e = perr(0, -10, 0, 0);
        checks++; if (out_err !== exp_e) begin errors++; $display("FAIL commit_err: got %h want %h", out_err, exp_e); end
        commit();
        send(0, 0, 0, 0);    // fb 14
        exp_e = perr(0, -14, 0, 0);
        checks++; if (out_err !== exp_e) begin errors++; $display("FAIL commit_late_err: got %h want %h", out_err, exp_e); end
        write_tap(1, 13, 0);
        commit();
    endtask

    task automatic test_hist_clear();
        clear_hist();
        send(102, 0, 0, 0);
        in_samples = pin(102, 0, 0, 0);
        in_valid   = 1'b1;
        hist_clear = 1'b1;
        cycle();
        in_valid   = 1'b0;
        hist_clear = 1'b0;
        exp_s = psyms(2, 0, 0, 0);
        exp_e = perr(-20, 0, 0, 0);   // old history used: f = 82
        checks++; if (out_syms !== exp_s) begin errors++; $display("FAIL hclr_same_syms: got %h want %h", out_syms, exp_s); end
        checks++; if (out_err !== exp_e) begin errors++; $display("FAIL hclr_same_err: got %h want %h", out_err, exp_e); end
        send(51, 0, 0, 0);
        exp_s = psyms(1, 0, 0, 0);
        checks++; if (out_syms !== exp_s) begin errors++; $display("FAIL hclr_after_syms: got %h want %h", out_syms, exp_s); end
        checks++; if (out_err !== 40'h0) begin errors++; $display("FAIL hclr_after_err: got %h want 0", out_err); end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 14; k++) write_tap(0, k, 127);
        commit();
        clear_hist();
        train_en   = 1'b1;
        train_syms = psyms(2, 0, 0, 0);
        for (int i = 0; i < 14; i++) send(0, 0, 0, 0);
        send(-128, 0, 0, 0);           // f = -128 - 3556 -> -512
        exp_s = psyms(-2, 0, 0, 0);
        exp_e = perr(-512, 0, 0, 0);   // -512 - 102 saturates
        checks++; if (out_syms !== exp_s) begin errors++; $display("FAIL sat_neg_syms: got %h want %h", out_syms, exp_s); end
        checks++; if (out_err !== exp_e) begin errors++; $display("FAIL sat_neg_err: got %h want %h", out_err, exp_e); end
        for (int k = 0; k < 14; k++) write_tap(0, k, -128);
        commit();
        train_syms = psyms(-2, 0, 0, 0);
        send(127, 0, 0, 0);            // f = 127 + 3584 -> 511
        train_en   = 1'b0;
        exp_s = psyms(2, 0, 0, 0);
        exp_e = perr(511, 0, 0, 0);    // 511 + 102 saturates
        checks++; if (out_syms !== exp_s) begin errors++; $display("FAIL sat_pos_syms: got %h want %h", out_syms, exp_s); end
        checks++; if (out_err !== exp_e) begin errors++; $display("FAIL sat_pos_err: got %h want %h", out_err, exp_e); end
        train_syms = '0;
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        send(51, 0, 0, 0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b want 1", out_valid); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_syms !== 12'h000 || out_err !== 40'h0) begin
            errors++; $display("FAIL mid_async_drop: valid %b syms %h err %h want 0 0 0", out_valid, out_syms, out_err);
        end
        cycle();
        reset_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
        out_ready = 1'b1;
        cycle();
        send(51, 0, 0, 0);             // taps and history back to zero
        exp_s = psyms(1, 0, 0, 0);
        checks++; if (out_syms !== exp_s) begin errors++; $display("FAIL mid_after_syms: got %h want %h", out_syms, exp_s); end
        checks++; if (out_err !== 40'h0) begin errors++; $display("FAIL mid_after_err: got %h want 0", out_err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_thresholds();
        test_taps();
        test_back_to_back();
        test_train();
        test_shadow();
        test_hist_clear();
        test_saturation();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
